mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu (multi-cycle control unit; sequences the shared-memory CPU datapath over IF/ID/EXE/MEM/WB)

---
 rtl/mc_cu.sv | 190 +++++++++++++++++++
 tb/tb_mc_cu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// Multi-cycle control unit: sequences the shared-memory CPU datapath through IF/ID/EXE/MEM/WB.
// Outputs are combinational from state and the instruction fields, and only the state is registered.
//   state | meaning
//   IF    | fetch: memory[PC] -> IR, PC+4 -> PC, waits on mem_ready
//   ID    | decode: branch target -> ALU-result register, resolves j/jal/jr/illegal
//   EXE   | execute: ALU op, address calc or branch compare
//   MEM   | data access at ALU-result address, waits on mem_ready
//   WB    | register file write-back
module mc_cu (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       shift,
  output logic       jal,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  logic       r_alu, r_shift, is_jr;
  logic [3:0] r_aluc;
  logic       i_alu, is_addi;
  logic [3:0] i_aluc;
  logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cur_state <= S_IF;
    else         cur_state <= nxt_state;
  end

  assign state = cur_state;

  always_comb begin
    r_alu   = 1'b0;
    r_shift = 1'b0;
    r_aluc  = 4'b0000;
    is_jr   = 1'b0;
    if (op == 6'h00) begin
      case (func)
        6'h20: r_alu = 1'b1;
        6'h22: begin r_alu = 1'b1; r_aluc = 4'b0100; end
        6'h24: begin r_alu = 1'b1; r_aluc = 4'b0001; end
        6'h25: begin r_alu = 1'b1; r_aluc = 4'b0101; end
        6'h26: begin r_alu = 1'b1; r_aluc = 4'b0010; end
        6'h00: begin r_alu = 1'b1; r_shift = 1'b1; r_aluc = 4'b0011; end
        6'h02: begin r_alu = 1'b1; r_shift = 1'b1; r_aluc = 4'b0111; end
        6'h03: begin r_alu = 1'b1; r_shift = 1'b1; r_aluc = 4'b1111; end
        6'h08: is_jr = 1'b1;
        default: ;
      endcase
    end

    i_alu   = 1'b0;
    is_addi = 1'b0;
    i_aluc  = 4'b0000;
    case (op)
      6'h08: begin i_alu = 1'b1; is_addi = 1'b1; end
      6'h0C: begin i_alu = 1'b1; i_aluc = 4'b0001; end
      6'h0D: begin i_alu = 1'b1; i_aluc = 4'b0101; end
      6'h0E: begin i_alu = 1'b1; i_aluc = 4'b0010; end
      6'h0F: begin i_alu = 1'b1; i_aluc = 4'b0110; end
      default: ;
    endcase

    is_lw  = (op == 6'h23);
    is_sw  = (op == 6'h2B);
    is_beq = (op == 6'h04);
    is_bne = (op == 6'h05);
    is_j   = (op == 6'h02);
    is_jal = (op == 6'h03);
    legal  = r_alu | is_jr | i_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
  end

  always_comb begin
    nxt_state = cur_state;
    wpc       = 1'b0;
    wir       = 1'b0;
    wmem      = 1'b0;
    wreg      = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    shift     = 1'b0;
    jal       = 1'b0;
    sext      = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluc      = 4'b0000;
    pcsource  = 2'b00;
    illegal   = 1'b0;

    case (cur_state)
      S_IF: begin
        alusrcb = 2'b01;
        wir     = mem_ready;
        wpc     = mem_ready;
        if (mem_ready) nxt_state = S_ID;
      end
      S_ID: begin
        alusrcb   = 2'b11;
        sext      = 1'b1;
        nxt_state = S_IF;
        if (is_j || is_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = is_jal;
          jal      = is_jal;
        end else if (is_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
        end else if (!legal) begin
          illegal = 1'b1;
        end else begin
          nxt_state = S_EXE;
        end
      end
      S_EXE: begin
        alusrca   = 1'b1;
        nxt_state = S_IF;
        if (r_alu) begin
          aluc      = r_aluc;
          shift     = r_shift;
          nxt_state = S_WB;
        end else if (i_alu) begin
          alusrcb   = 2'b10;
          sext      = is_addi;
          aluc      = i_aluc;
          nxt_state = S_WB;
        end else if (is_lw || is_sw) begin
          alusrcb   = 2'b10;
          sext      = 1'b1;
          nxt_state = S_MEM;
        end else if (is_beq || is_bne) begin
          aluc = 4'b0100;
          sext = 1'b1;
          if ((is_beq && zero) || (is_bne && !zero)) begin
            wpc      = 1'b1;
            pcsource = 2'b01;
          end
        end
      end
      S_MEM: begin
        iord = 1'b1;
        wmem = is_sw;
        if (mem_ready) nxt_state = is_lw ? S_WB : S_IF;
      end
      S_WB: begin
        wreg      = 1'b1;
        regrt     = !(op == 6'h00);
        m2reg     = is_lw;
        nxt_state = S_IF;
      end
      default: nxt_state = S_IF;
    endcase

    // Strobes must stay quiet while reset is held, even though IF follows mem_ready.
    if (!resetn) begin
      wpc     = 1'b0;
      wir     = 1'b0;
      wmem    = 1'b0;
      wreg    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: directed scenarios plus randomized instruction streams checked against a
// mnemonic-level model of each instruction's phase walk and latency.
module tb_mc_cu;

  logic       clock, resetn;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext, alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic [2:0] state;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int PH_IF = 0, PH_ID = 1, PH_EXE = 2, PH_MEM = 3, PH_WB = 4;
  localparam int K_R = 0, K_SH = 1, K_IALU = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_BNE = 6,
                 K_J = 7, K_JAL = 8, K_JR = 9;

  typedef struct {
    int         kind;
    logic [3:0] alu;
    int         lat;
  } info_t;

  info_t info[string];

  mc_cu dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt), .m2reg(m2reg),
    .shift(shift), .jal(jal), .sext(sext), .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc),
    .pcsource(pcsource), .state(state), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic string mnem(input logic [5:0] o, input logic [5:0] f);
    string m = "";
    if (o == 6'h00) begin
      case (f)
        6'h20: m = "add";  6'h22: m = "sub"; 6'h24: m = "and"; 6'h25: m = "or";
        6'h26: m = "xor";  6'h00: m = "sll"; 6'h02: m = "srl"; 6'h03: m = "sra";
        6'h08: m = "jr";
        default: m = "";
      endcase
    end else begin
      case (o)
        6'h08: m = "addi"; 6'h0C: m = "andi"; 6'h0D: m = "ori"; 6'h0E: m = "xori";
        6'h0F: m = "lui";  6'h23: m = "lw";   6'h2B: m = "sw";  6'h04: m = "beq";
        6'h05: m = "bne";  6'h02: m = "j";    6'h03: m = "jal";
        default: m = "";
      endcase
    end
    return m;
  endfunction

  // Expected {state, strobes, controls} for one cycle of instruction m, plus the next phase.
  function automatic void model(input int ph, input string m, input logic z, input logic mr,
                                output logic [22:0] v, output int nph);
    logic e_wpc = 0, e_wir = 0, e_wmem = 0, e_wreg = 0, e_iord = 0, e_regrt = 0, e_m2reg = 0;
    logic e_shift = 0, e_jal = 0, e_sext = 0, e_srca = 0, e_ill = 0;
    logic [1:0] e_srcb = 0, e_pcs = 0;
    logic [3:0] e_aluc = 0;
    int k;
    k = info.exists(m) ? info[m].kind : -1;
    nph = PH_IF;
    case (ph)
      PH_IF: begin
        e_srcb = 2'b01; e_wir = mr; e_wpc = mr;
        nph = mr ? PH_ID : PH_IF;
      end
      PH_ID: begin
        e_srcb = 2'b11; e_sext = 1;
        if (k < 0) e_ill = 1;
        else if (k == K_J || k == K_JAL) begin
          e_wpc = 1; e_pcs = 2'b11; e_wreg = (k == K_JAL); e_jal = (k == K_JAL);
        end else if (k == K_JR) begin
          e_wpc = 1; e_pcs = 2'b10;
        end else nph = PH_EXE;
      end
      PH_EXE: begin
        e_srca = 1;
        if (k == K_R || k == K_SH) begin
          e_aluc = info[m].alu; e_shift = (k == K_SH); nph = PH_WB;
        end else if (k == K_IALU) begin
          e_srcb = 2'b10; e_sext = (m == "addi"); e_aluc = info[m].alu; nph = PH_WB;
        end else if (k == K_LW || k == K_SW) begin
          e_srcb = 2'b10; e_sext = 1; nph = PH_MEM;
        end else begin
          e_aluc = 4'b0100; e_sext = 1;
          if ((k == K_BEQ) == z) begin e_wpc = 1; e_pcs = 2'b01; end
        end
      end
      PH_MEM: begin
        e_iord = 1; e_wmem = (k == K_SW);
        nph = !mr ? PH_MEM : (k == K_LW ? PH_WB : PH_IF);
      end
      default: begin
        e_wreg = 1; e_regrt = (k == K_IALU || k == K_LW); e_m2reg = (k == K_LW);
      end
    endcase
    v = {3'(ph), e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_shift, e_jal,
         e_sext, e_srca, e_srcb, e_aluc, e_pcs, e_ill};
  endfunction

  task automatic test_reset();
    resetn = 0; mem_ready = 1; op = 6'h00; func = 6'h20; zero = 0;
    #3;
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_tests++; if ({wpc, wir, wmem, wreg, illegal} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 00000", {wpc, wir, wmem, wreg, illegal}); end
    tick();
    n_tests++; if ({state, wpc, wir} !== 5'b0) begin
      n_fail++; $display("FAIL reset_held got %b want 00000", {state, wpc, wir}); end
    resetn = 1; #1;
    n_tests++; if ({wir, wpc} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_fetch got %b want 11", {wir, wpc}); end
  endtask

  task automatic test_add();
    op = 6'h00; func = 6'h20; mem_ready = 1; zero = 0; #1;
    tick();
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL add_id got %0d want 1", state); end
    tick();
    n_tests++; if ({state, alusrca, alusrcb, aluc} !== {3'd2, 1'b1, 2'b00, 4'b0000}) begin
      n_fail++; $display("FAIL add_exe got %b want 0101000000", {state, alusrca, alusrcb, aluc}); end
    tick();
    n_tests++; if ({state, wreg, regrt} !== {3'd4, 2'b10}) begin
      n_fail++; $display("FAIL add_wb got %b want 10010", {state, wreg, regrt}); end
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL add_done got %0d want 0", state); end
  endtask

  task automatic test_lw_wait();
    op = 6'h23; func = 6'h00; mem_ready = 1; #1;
    tick(); tick(); tick();
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1;
      #1;
      n_tests++; if ({state, iord} !== {3'd3, 1'b1}) begin
        n_fail++; $display("FAIL lw_mem%0d got %b want 0111", i, {state, iord}); end
      tick();
    end
    n_tests++; if ({state, m2reg, wreg} !== {3'd4, 2'b11}) begin
      n_fail++; $display("FAIL lw_wb got %b want 10011", {state, m2reg, wreg}); end
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL lw_done got %0d want 0", state); end
  endtask

  task automatic test_branch();
    logic taken;
    for (int k = 0; k < 4; k++) begin
      op = (k < 2) ? 6'h04 : 6'h05; zero = k[0]; mem_ready = 1;
      taken = (k < 2) ? zero : !zero;
      tick(); tick();
      n_tests++; if ({state, wpc, pcsource} !== {3'd2, taken, taken ? 2'b01 : 2'b00}) begin
        n_fail++; $display("FAIL branch%0d got %b want %b", k, {state, wpc, pcsource},
                           {3'd2, taken, taken ? 2'b01 : 2'b00}); end
      tick();
      n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL branch%0d_done got %0d want 0", k, state); end
    end
  endtask

  task automatic test_jal_illegal();
    op = 6'h03; mem_ready = 1; #1;
    tick();
    n_tests++; if ({state, wpc, pcsource, wreg, jal} !== {3'd1, 5'b11111}) begin
      n_fail++; $display("FAIL jal_id got %b want 00111111", {state, wpc, pcsource, wreg, jal}); end
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL jal_done got %0d want 0", state); end
    op = 6'h3F; #1;
    tick();
    n_tests++; if ({state, illegal, wpc, wir, wmem, wreg} !== {3'd1, 5'b10000}) begin
      n_fail++; $display("FAIL illegal_id got %b want 00110000", {state, illegal, wpc, wir, wmem, wreg}); end
    tick();
    n_tests++; if ({state, illegal} !== 4'b0) begin
      n_fail++; $display("FAIL illegal_done got %b want 0000", {state, illegal}); end
  endtask

  task automatic test_sw_reset();
    op = 6'h2B; mem_ready = 1; #1;
    tick(); tick(); tick();
    mem_ready = 0; #1;
    n_tests++; if ({state, wmem} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL sw_mem got %b want 0111", {state, wmem}); end
    mem_ready = 1; resetn = 0; #1;
    n_tests++; if ({state, wpc, wir, wmem, wreg} !== 7'b0) begin
      n_fail++; $display("FAIL sw_async_reset got %b want 0000000", {state, wpc, wir, wmem, wreg}); end
    tick();
    resetn = 1; mem_ready = 0; #1;
    n_tests++; if ({state, wir} !== 4'b0) begin
      n_fail++; $display("FAIL sw_release_wait got %b want 0000", {state, wir}); end
    tick();
    mem_ready = 1; op = 6'h02; #1;
    tick();
    n_tests++; if ({state, wpc, pcsource} !== {3'd1, 3'b111}) begin
      n_fail++; $display("FAIL sw_refetch got %b want 001111", {state, wpc, pcsource}); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0]  tab_op[20] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h02, 6'h03};
    logic [5:0]  tab_fn[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08};
    logic [22:0] exp_v, got_v;
    string       m;
    int          ph, nph, cyc, waits, lat, sel;
    bit          done;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(4) == 0) begin
        op = 6'($urandom); func = 6'($urandom);
      end else begin
        sel = $urandom_range(19);
        op = tab_op[sel]; func = (sel < 9) ? tab_fn[sel] : 6'($urandom);
      end
      m = mnem(op, func);
      lat = info.exists(m) ? info[m].lat : 2;
      ph = PH_IF; cyc = 0; waits = 0; done = 0;
      while (!done) begin
        mem_ready = ($urandom_range(2) != 0); zero = 1'($urandom);
        #1;
        model(ph, m, zero, mem_ready, exp_v, nph);
        got_v = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, jal, sext, alusrca,
                 alusrcb, aluc, pcsource, illegal};
        n_tests++; if (got_v !== exp_v) begin
          n_fail++; $display("FAIL rand_%s_ph%0d got %b want %b", m, ph, got_v, exp_v); end
        cyc++;
        if (!mem_ready && (ph == PH_IF || ph == PH_MEM)) waits++;
        tick();
        done = (nph == PH_IF && ph != PH_IF);
        ph = nph;
        if (cyc > 80) begin
          n_tests++; n_fail++;
          $display("FAIL rand_%s_timeout got %0d cycles want done", m, cyc);
          done = 1;
        end
      end
      n_tests++; if (cyc !== lat + waits) begin
        n_fail++; $display("FAIL rand_%s_latency got %0d want %0d", m, cyc, lat + waits); end
    end
  endtask

  initial begin
    info["add"]  = '{K_R, 4'b0000, 4};   info["sub"]  = '{K_R, 4'b0100, 4};
    info["and"]  = '{K_R, 4'b0001, 4};   info["or"]   = '{K_R, 4'b0101, 4};
    info["xor"]  = '{K_R, 4'b0010, 4};   info["sll"]  = '{K_SH, 4'b0011, 4};
    info["srl"]  = '{K_SH, 4'b0111, 4};  info["sra"]  = '{K_SH, 4'b1111, 4};
    info["jr"]   = '{K_JR, 4'b0000, 2};  info["addi"] = '{K_IALU, 4'b0000, 4};
    info["andi"] = '{K_IALU, 4'b0001, 4}; info["ori"] = '{K_IALU, 4'b0101, 4};
    info["xori"] = '{K_IALU, 4'b0010, 4}; info["lui"] = '{K_IALU, 4'b0110, 4};
    info["lw"]   = '{K_LW, 4'b0000, 5};  info["sw"]   = '{K_SW, 4'b0000, 4};
    info["beq"]  = '{K_BEQ, 4'b0100, 3}; info["bne"]  = '{K_BNE, 4'b0100, 3};
    info["j"]    = '{K_J, 4'b0000, 2};   info["jal"]  = '{K_JAL, 4'b0000, 2};

    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jal_illegal();
    test_sw_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
